miller_encoder: RTL

Modified Miller transmitter for the ISO/IEC 14443 Type A reader-to-card link at 106 kb/s: the encoding counterpart of the team's Modified Miller receive chain and its EoF detector. Accepts bytes over a valid/ready handshake, appends an odd parity bit per byte, serialises LSB first and emits the frame as SoF, data and EoF sequences on a single pause (carrier-off) output. It sits between the frame builder and the RF modulator driver, clocked at fc/16 (847.5 kHz, 8 clocks per ETU).

---
 rtl/miller_encoder_pkg.sv | 31 +++
 rtl/miller_encoder_seq_gen.sv | 41 ++++
 rtl/miller_encoder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/miller_encoder_pkg.sv
// Shared types for the Modified Miller transmit path:
// sequence codes, FSM states and default timing.
package miller_encoder_pkg;

  localparam int N_ETU_DEF = 8;
  localparam int PAUSE_DEF = 2;

  typedef enum logic [1:0] {
    SEQ_Y = 2'd0,
    SEQ_X = 2'd1,
    SEQ_Z = 2'd2
  } seq_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SOF    = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_EOF0   = 3'd4,
    S_EOFY   = 3'd5
  } state_t;

  function automatic seq_t bit_seq(
    input logic b,
    input logic prev_zero
  );
    if (b) return SEQ_X;
    return prev_zero ? SEQ_Z : SEQ_Y;
  endfunction

endpackage

// File: rtl/miller_encoder_seq_gen.sv
// Turns a Miller sequence code plus the ETU clock
// position into the registered carrier-pause line.
module miller_seq_gen
  import miller_encoder_pkg::*;
#(
  parameter int N_ETU = N_ETU_DEF,
  parameter int PAUSE = PAUSE_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  seq_t                     seq,
  input  logic [$clog2(N_ETU)-1:0] cnt,
  output logic                     pause
);

  localparam int CW = $clog2(N_ETU);
  localparam logic [CW:0] HALF = (CW+1)'(N_ETU / 2);
  localparam logic [CW:0] XEND = (CW+1)'(N_ETU / 2 + PAUSE);
  localparam logic [CW:0] ZEND = (CW+1)'(PAUSE);

  logic [CW:0] c;
  logic        hit;

  assign c = {1'b0, cnt};

  always_comb begin
    hit = 1'b0;
    unique case (seq)
      SEQ_X:   hit = (c >= HALF) && (c < XEND);
      SEQ_Z:   hit = (c < ZEND);
      default: hit = 1'b0;
    endcase
  end

  // Miller chain flops all run on the falling edge
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) pause <= 1'b0;
    else        pause <= hit;
  end

endmodule

// File: rtl/miller_encoder.sv
// ISO 14443A reader-to-card Modified Miller encoder:
// byte handshake in, odd parity, SoF/data/EoF pause line out.
module miller_encoder
  import miller_encoder_pkg::*;
#(
  parameter int N_ETU = N_ETU_DEF,
  parameter int PAUSE = PAUSE_DEF
) (
  input  logic       in_clk,
  input  logic       in_PoR,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  input  logic       in_last,
  output logic       out_ready,
  output logic       out_pause,
  output logic       out_busy,
  output logic       out_done,
  output logic       out_underrun
);

  localparam int CW = $clog2(N_ETU);
  localparam logic [CW-1:0] LAST_CNT = CW'(N_ETU - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic          wrap;
  logic [7:0]    hold;
  logic          hold_full;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          par;
  logic          prev_zero;
  logic          last_flag;
  logic          und_flag;
  logic          und_set;
  logic          accept;
  logic          reload;
  logic          frame_end;
  logic          cur_bit;
  seq_t          seq;

  assign wrap      = (cnt == LAST_CNT);
  assign out_ready = !hold_full && !last_flag &&
                     (state != S_EOF0) && (state != S_EOFY);
  assign accept    = in_valid && out_ready;
  assign reload    = wrap && ((state == S_SOF) ||
                     (state == S_PARITY && hold_full));
  assign frame_end = wrap && (state == S_EOFY);
  assign out_busy  = (state != S_IDLE);

  always_comb begin
    cur_bit = 1'b0;
    seq     = SEQ_Y;
    unique case (state)
      S_SOF:    seq = SEQ_Z;
      S_DATA: begin
        cur_bit = shreg[0];
        seq     = bit_seq(cur_bit, prev_zero);
      end
      S_PARITY: begin
        cur_bit = par;
        seq     = bit_seq(cur_bit, prev_zero);
      end
      S_EOF0:   seq = bit_seq(1'b0, prev_zero);
      default:  seq = SEQ_Y;
    endcase
  end

  always_comb begin
    state_nx = state;
    und_set  = 1'b0;
    unique case (state)
      // a full holding register in IDLE restarts too
      S_IDLE:
        if (accept || hold_full) state_nx = S_SOF;
      S_SOF:
        if (wrap) state_nx = S_DATA;
      S_DATA:
        if (wrap && bit_idx == 3'd7) state_nx = S_PARITY;
      S_PARITY:
        if (wrap) begin
          if (hold_full) begin
            state_nx = S_DATA;
          end else begin
            state_nx = S_EOF0;
            und_set  = !last_flag;
          end
        end
      S_EOF0:
        if (wrap) state_nx = S_EOFY;
      S_EOFY:
        if (wrap) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(negedge in_clk or negedge in_PoR) begin
    if (!in_PoR) begin
      state        <= S_IDLE;
      cnt          <= '0;
      hold         <= '0;
      hold_full    <= 1'b0;
      shreg        <= '0;
      bit_idx      <= '0;
      par          <= 1'b0;
      prev_zero    <= 1'b0;
      last_flag    <= 1'b0;
      und_flag     <= 1'b0;
      out_done     <= 1'b0;
      out_underrun <= 1'b0;
    end else begin
      state        <= state_nx;
      out_done     <= frame_end;
      out_underrun <= frame_end && und_flag;
      if (state == S_IDLE) cnt <= '0;
      else if (wrap)       cnt <= '0;
      else                 cnt <= cnt + CW'(1);
      if (wrap) begin
        unique case (state)
          S_SOF:    prev_zero <= 1'b1;
          S_DATA: begin
            prev_zero <= ~shreg[0];
            shreg     <= shreg >> 1;
            bit_idx   <= bit_idx + 3'd1;
          end
          S_PARITY: prev_zero <= ~par;
          S_EOF0:   prev_zero <= 1'b1;
          default:  ;
        endcase
      end
      if (und_set) und_flag <= 1'b1;
      if (frame_end) begin
        last_flag <= 1'b0;
        und_flag  <= 1'b0;
      end
      if (reload) begin
        shreg     <= hold;
        par       <= ~^hold;
        bit_idx   <= '0;
        hold_full <= 1'b0;
      end
      // refill after free when both land on one edge
      if (accept) begin
        hold      <= in_byte;
        hold_full <= 1'b1;
        if (in_last) last_flag <= 1'b1;
      end
    end
  end

  miller_seq_gen #(
    .N_ETU(N_ETU),
    .PAUSE(PAUSE)
  ) u_seq (
    .clk  (in_clk),
    .rst_n(in_PoR),
    .seq  (seq),
    .cnt  (cnt),
    .pause(out_pause)
  );

endmodule
